// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared constants for the data memory / peripheral window.
//   - Register byte offsets inside the 32-byte peripheral window.
//   - Bit positions inside the STAT register.
//   - Reset value of the timer compare register.
package dmem_mmio_pkg;

  localparam logic [4:0] OFF_SW    = 5'h00;
  localparam logic [4:0] OFF_LED   = 5'h04;
  localparam logic [4:0] OFF_EDGE  = 5'h08;
  localparam logic [4:0] OFF_COUNT = 5'h0C;
  localparam logic [4:0] OFF_CMP   = 5'h10;
  localparam logic [4:0] OFF_STAT  = 5'h14;

  localparam int STAT_MATCH = 0;
  localparam int STAT_EN    = 1;
  localparam int STAT_AUTO  = 2;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_mmio_sync_edge.sv
// sync_edge: two-flop synchroniser for asynchronous inputs, followed by a
// delayed copy used for rising-edge detection.
//   clk      in  clock, rising edge
//   reset    in  synchronous, active-low reset (clears all flops)
//   async_in in  W asynchronous inputs
//   sync     out W synchronised inputs
//   rise     out W one-cycle pulse where sync=1 and the delayed copy=0
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM with byte-lane writes plus a small peripheral window
// (switches with sticky edge capture, LED register, timer with compare,
// auto-reload and interrupt). Reads are combinational from the address.
//   clk      in  clock, rising edge
//   reset    in  synchronous, active-low reset (RAM contents are kept)
//   we       in  write strobe
//   be       in  4 byte enables, RAM only
//   a        in  32 byte address, bits [1:0] ignored
//   wd       in  32 write data
//   rd       out 32 read data, combinational
//   switches in  NSW asynchronous switch inputs
//   leds     out NLED LED register
//   irq      out timer interrupt (MATCH flag)
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          NSW       = 10,
  parameter int          NLED      = 10,
  parameter logic [31:0] MMIO_BASE = 32'hC000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [31:0]     a,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [NSW-1:0]  switches,
  output logic [NLED-1:0] leds,
  output logic            irq
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  // ---------------- decode ----------------
  logic          ram_sel, mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [4:0]    off;
  logic          unused_lsb;

  assign ram_sel    = (a < RAM_BYTES);
  assign mmio_sel   = (a[31:5] == MMIO_BASE[31:5]);
  assign ram_idx    = a[AW+1:2];
  assign off        = {a[4:2], 2'b00};
  assign unused_lsb = ^a[1:0];

  logic wr_led, wr_edge, wr_count, wr_cmp, wr_stat;
  assign wr_led   = we && mmio_sel && (off == OFF_LED);
  assign wr_edge  = we && mmio_sel && (off == OFF_EDGE);
  assign wr_count = we && mmio_sel && (off == OFF_COUNT);
  assign wr_cmp   = we && mmio_sel && (off == OFF_CMP);
  assign wr_stat  = we && mmio_sel && (off == OFF_STAT);

  // ---------------- RAM ----------------
  logic [31:0] mem [DEPTH];

  // RAM ignores reset: a write coincident with reset still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && ram_sel && be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  // ---------------- switches ----------------
  logic [NSW-1:0] sw_sync, sw_rise;

  sync_edge #(.W(NSW)) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (switches),
    .sync     (sw_sync),
    .rise     (sw_rise)
  );

  // ---------------- peripheral registers ----------------
  logic [NLED-1:0] leds_q, leds_d;
  logic [NSW-1:0]  edge_q, edge_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     cmp_q, cmp_d;
  logic            match_q, match_d;
  logic            en_q, en_d;
  logic            auto_q, auto_d;
  logic            hit;

  assign hit = en_q && (count_q == cmp_q);

  always_comb begin
    leds_d  = leds_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    auto_d  = auto_q;
    count_d = count_q;

    if (wr_led) leds_d = wd[NLED-1:0];
    if (wr_cmp) cmp_d  = wd;
    if (wr_stat) begin
      en_d   = wd[STAT_EN];
      auto_d = wd[STAT_AUTO];
    end

    // Set terms are OR-ed in after the clear so a fresh event survives a W1C.
    edge_d  = (edge_q & ~(wr_edge ? wd[NSW-1:0] : '0)) | sw_rise;
    match_d = (match_q & ~(wr_stat & wd[STAT_MATCH])) | hit;

    // A software load beats both the increment and the auto-reload.
    if (wr_count)           count_d = wd;
    else if (hit && auto_q) count_d = '0;
    else if (en_q)          count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      leds_q  <= '0;
      edge_q  <= '0;
      count_q <= '0;
      cmp_q   <= CMP_RST;
      match_q <= 1'b0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      edge_q  <= edge_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
    end
  end

  assign leds = leds_q;
  assign irq  = match_q;

  // ---------------- read mux ----------------
  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = mem[ram_idx];
    end else if (mmio_sel) begin
      case (off)
        OFF_SW:    rd[NSW-1:0]  = sw_sync;
        OFF_LED:   rd[NLED-1:0] = leds_q;
        OFF_EDGE:  rd[NSW-1:0]  = edge_q;
        OFF_COUNT: rd           = count_q;
        OFF_CMP:   rd           = cmp_q;
        OFF_STAT: begin
          rd[STAT_MATCH] = match_q;
          rd[STAT_EN]    = en_q;
          rd[STAT_AUTO]  = auto_q;
        end
        default:   rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio with default
// parameters (64-word RAM, 10 switches, 10 LEDs, window at 0xC000_0000).
module tb_dmem_mmio;

  localparam logic [31:0] BASE    = 32'hC000_0000;
  localparam logic [31:0] A_SW    = BASE + 32'h00;
  localparam logic [31:0] A_LED   = BASE + 32'h04;
  localparam logic [31:0] A_EDGE  = BASE + 32'h08;
  localparam logic [31:0] A_COUNT = BASE + 32'h0C;
  localparam logic [31:0] A_CMP   = BASE + 32'h10;
  localparam logic [31:0] A_STAT  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a, wd, rd;
  logic [9:0]  switches, leds;
  logic        irq;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  dmem_mmio #(
    .DEPTH     (64),
    .NSW       (10),
    .NLED      (10),
    .MMIO_BASE (32'hC000_0000),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .be       (be),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bytes);
    a  = addr;
    wd = data;
    be = bytes;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    $display("[TB] write a=%h wd=%h be=%b", addr, data, bytes);
  endtask

  task automatic rdw(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
    $display("[TB] read  a=%h rd=%h", addr, data);
  endtask

  task automatic test_reset;
    reset = 1'b0; we = 1'b0; a = '0; wd = '0; be = '0; switches = '0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    tests++; if (leds !== 10'h0) begin fails++; $display("FAIL rst_leds got %h want 000", leds); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got %b want 0", irq); end
    rdw(A_COUNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_count got %h want 00000000", v); end
    rdw(A_CMP, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_cmp got %h want ffffffff", v); end
    rdw(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_stat got %h want 00000000", v); end
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_edge got %h want 00000000", v); end
  endtask

  task automatic test_ram_lanes;
    wr(32'h10, 32'hAABB_CCDD, 4'hF);
    rdw(32'h10, v);
    tests++; if (v !== 32'hAABB_CCDD) begin fails++; $display("FAIL ram_full got %h want aabbccdd", v); end
    // partial write; the read in the write cycle must still see old data
    a = 32'h10; wd = 32'h1122_3344; be = 4'b0101; we = 1'b1;
    #1;
    tests++; if (rd !== 32'hAABB_CCDD) begin fails++; $display("FAIL ram_old got %h want aabbccdd", rd); end
    @(posedge clk);
    #1;
    we = 1'b0;
    rdw(32'h10, v);
    tests++; if (v !== 32'hAA22_CC44) begin fails++; $display("FAIL ram_lanes got %h want aa22cc44", v); end
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    rdw(32'h100, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ram_unmapped got %h want 00000000", v); end
    rdw(BASE + 32'h18, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL mmio_hole got %h want 00000000", v); end
    rdw(32'h10, v);
    tests++; if (v !== 32'hAA22_CC44) begin fails++; $display("FAIL ram_alias got %h want aa22cc44", v); end
  endtask

  task automatic test_switches;
    switches = 10'h201;
    tick;
    rdw(A_SW, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL sw_1edge got %h want 00000000", v); end
    tick;
    rdw(A_SW, v);
    tests++; if (v !== 32'h201) begin fails++; $display("FAIL sw_2edge got %h want 00000201", v); end
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL edge_2edge got %h want 00000000", v); end
    tick;
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h201) begin fails++; $display("FAIL edge_3edge got %h want 00000201", v); end
    wr(A_EDGE, 32'h001, 4'h0);
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h200) begin fails++; $display("FAIL edge_w1c got %h want 00000200", v); end
    // bit 1 rises on the same edge that tries to clear it
    switches = 10'h203;
    tick;
    tick;
    wr(A_EDGE, 32'h002, 4'h0);
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h202) begin fails++; $display("FAIL edge_set_wins got %h want 00000202", v); end
    wr(A_EDGE, 32'h200, 4'h0);
    rdw(A_EDGE, v);
    tests++; if (v !== 32'h002) begin fails++; $display("FAIL edge_w1c2 got %h want 00000002", v); end
    rdw(A_SW, v);
    tests++; if (v !== 32'h203) begin fails++; $display("FAIL sw_read got %h want 00000203", v); end
  endtask

  task automatic test_leds;
    wr(A_LED, 32'hFFFF_F3A5, 4'h0);
    tests++; if (leds !== 10'h3A5) begin fails++; $display("FAIL leds_out got %h want 3a5", leds); end
    rdw(A_LED, v);
    tests++; if (v !== 32'h3A5) begin fails++; $display("FAIL leds_read got %h want 000003a5", v); end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tests++; if (leds !== 10'h0) begin fails++; $display("FAIL leds_reset got %h want 000", leds); end
  endtask

  task automatic test_timer_oneshot;
    wr(A_CMP, 32'd5, 4'h0);
    wr(A_STAT, 32'h2, 4'h0);
    rdw(A_COUNT, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL os_start got %h want 00000000", v); end
    for (int k = 1; k <= 7; k++) begin
      tick;
      rdw(A_COUNT, v);
      tests++; if (v !== 32'(k)) begin fails++; $display("FAIL os_count[%0d] got %h want %h", k, v, 32'(k)); end
      tests++; if (irq !== (k >= 6)) begin fails++; $display("FAIL os_irq[%0d] got %b want %b", k, irq, (k >= 6)); end
    end
    wr(A_STAT, 32'h3, 4'h0);
    rdw(A_STAT, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL os_stat_w1c got %h want 00000002", v); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL os_irq_clr got %b want 0", irq); end
    rdw(A_COUNT, v);
    tests++; if (v !== 32'd8) begin fails++; $display("FAIL os_count_after got %h want 00000008", v); end
  endtask

  task automatic test_timer_auto;
    wr(A_STAT, 32'h0, 4'h0);
    wr(A_COUNT, 32'h0, 4'h0);
    wr(A_CMP, 32'd3, 4'h0);
    wr(A_STAT, 32'h6, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      tick;
      rdw(A_COUNT, v);
      tests++; if (v !== 32'(k % 4)) begin fails++; $display("FAIL ar_count[%0d] got %h want %h", k, v, 32'(k % 4)); end
      tests++; if (irq !== (k >= 4)) begin fails++; $display("FAIL ar_irq[%0d] got %b want %b", k, irq, (k >= 4)); end
    end
    // COUNT==CMP now: the load must beat the reload
    wr(A_COUNT, 32'd100, 4'h0);
    rdw(A_COUNT, v);
    tests++; if (v !== 32'd100) begin fails++; $display("FAIL ar_load_wins got %h want 00000064", v); end
    tick;
    rdw(A_COUNT, v);
    tests++; if (v !== 32'd101) begin fails++; $display("FAIL ar_after_load got %h want 00000065", v); end
    wr(A_STAT, 32'h1, 4'h0);
    wr(A_CMP, 32'hFFFF_FFFE, 4'h0);
    wr(A_COUNT, 32'hFFFF_FFFF, 4'h0);
    wr(A_STAT, 32'h2, 4'h0);
    rdw(A_COUNT, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_pre got %h want ffffffff", v); end
    tick;
    rdw(A_COUNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL wrap_count got %h want 00000000", v); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL wrap_irq got %b want 0", irq); end
  endtask

  task automatic test_reset_mid;
    wr(A_STAT, 32'h0, 4'h0);
    wr(A_CMP, 32'd20, 4'h0);
    wr(A_COUNT, 32'h0, 4'h0);
    wr(A_LED, 32'h155, 4'h0);
    wr(A_STAT, 32'h2, 4'h0);
    repeat (7) tick;
    rdw(A_COUNT, v);
    tests++; if (v !== 32'd7) begin fails++; $display("FAIL mid_count7 got %h want 00000007", v); end
    reset = 1'b0;
    wr(A_LED, 32'h3FF, 4'h0);
    wr(32'h20, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    tests++; if (leds !== 10'h0) begin fails++; $display("FAIL mid_leds got %h want 000", leds); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got %b want 0", irq); end
    rdw(A_COUNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL mid_count got %h want 00000000", v); end
    rdw(A_CMP, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mid_cmp got %h want ffffffff", v); end
    rdw(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL mid_stat got %h want 00000000", v); end
    rdw(32'h10, v);
    tests++; if (v !== 32'hAA22_CC44) begin fails++; $display("FAIL mid_ram_keep got %h want aa22cc44", v); end
    rdw(32'h20, v);
    tests++; if (v !== 32'h1234_5678) begin fails++; $display("FAIL mid_ram_wr got %h want 12345678", v); end
    tick;
    rdw(A_COUNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL mid_hold got %h want 00000000", v); end
  endtask

  initial begin
    test_reset();
    test_ram_lanes();
    test_switches();
    test_leds();
    test_timer_oneshot();
    test_timer_auto();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
